// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one combinational shifter between two requesters.
// Operands are registered onto the shifter, the result is captured and returned with the requester id.
//
// state | meaning
// IDLE  | waiting for a request; grants one requester and registers its operands
// EXEC  | shifter settles on registered operands; result captured at end of cycle
// RESP  | response presented and held until rsp_ready
module shift_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_dir,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_dir,
    output logic             req1_ready,
    output logic [WIDTH-1:0] sh_a,
    output logic [WIDTH-1:0] sh_b,
    input  logic [WIDTH-1:0] sh_left,
    input  logic [WIDTH-1:0] sh_right,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    input  logic             rsp_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic             dir_q, dir_d;
    logic             id_q, id_d;
    logic             last_grant_q, last_grant_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic grant_vld;
    logic grant_id;
    logic accept;

    // Under contention the requester that did not win last time gets the grant.
    always_comb begin
        grant_vld = req0_valid | req1_valid;
        grant_id  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
        accept    = !rst && (state_q == IDLE) && grant_vld;
    end

    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept &&  grant_id;

    always_comb begin
        state_d      = state_q;
        sh_a_d       = sh_a_q;
        sh_b_d       = sh_b_q;
        dir_d        = dir_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    sh_a_d       = grant_id ? req1_a   : req0_a;
                    sh_b_d       = grant_id ? req1_b   : req0_b;
                    dir_d        = grant_id ? req1_dir : req0_dir;
                    id_d         = grant_id;
                    last_grant_d = grant_id;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d  = dir_q ? sh_right : sh_left;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sh_a_q       <= '0;
            sh_b_q       <= '0;
            dir_q        <= 1'b0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            sh_a_q       <= sh_a_d;
            sh_b_q       <= sh_b_d;
            dir_q        <= dir_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign sh_a      = sh_a_q;
    assign sh_b      = sh_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule
